// File: rtl/pipe_reg_pkg.sv
// Shared defaults and helpers for the elastic register chain.
// The stage struct describes one valid/data pair at the default width.
package pipe_reg_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One valid/data slot of the register chain; loads from upstream when adv is high.
// Build option PIPE_REG_DATA_RESET_EN also clears the data flops on reset and flush.
module pipe_reg_stage
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_reg <= 1'b0;
        end else if (adv) begin
            valid_reg <= up_valid;
        end
    end

`ifdef PIPE_REG_DATA_RESET_EN
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            data_reg <= '0;
        end else if (adv) begin
            data_reg <= up_data;
        end
    end
`else
    // Data flops carry no reset; a flush leaves their contents untouched.
    always_ff @(posedge clk) begin
        if (adv && !flush) begin
            data_reg <= up_data;
        end
    end
`endif

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_register_chain.sv
// Elastic DEPTH-stage register with valid/ready at both ends, flush and occupancy count.
// Build option PIPE_REG_DATA_RESET_EN clears stage data on reset and flush.
module pipe_register_chain
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic             accept;
    logic             emit;
    logic [OCC_W-1:0] occ_reg;

    // A stage may move when the next one moves or when it holds nothing,
    // so bubbles are squeezed out; in_ready therefore depends on out_ready.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = out_ready | ~v[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = adv[k+1] | ~v[k];
        end
    end

    assign in_ready = adv[0] & ~flush;
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign up_v[gi] = accept;
                assign up_d[gi] = in_data;
            end else begin : g_body
                assign up_v[gi] = v[gi-1];
                assign up_d[gi] = d[gi-1];
            end

            pipe_reg_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .adv      (adv[gi]),
                .up_valid (up_v[gi]),
                .up_data  (up_d[gi]),
                .valid    (v[gi]),
                .data     (d[gi])
            );
        end
    endgenerate

    // Tracks popcount(v) incrementally; flush wins over any same-cycle emit.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            occ_reg <= '0;
        end else if (accept && !emit) begin
            occ_reg <= occ_reg + OCC_ONE;
        end else if (emit && !accept) begin
            occ_reg <= occ_reg - OCC_ONE;
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ_reg;

endmodule

// File: tb/tb_pipe_register_chain.sv
// Scoreboard bench for pipe_register_chain (WIDTH=32, DEPTH=4).
// Inputs change 1 ns after the rising edge; everything is observed on the falling edge.
module tb_pipe_register_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] sb [$];

    always #5 clk = ~clk;

    pipe_register_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // Scoreboard: push on accept, pop and compare on emit, discard on flush/reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            tests++;
            if (occupancy !== OCC_W'(sb.size())) begin
                fails++;
                $display("[TB] FAIL sb_occupancy: got %0d expected %0d", occupancy, sb.size());
            end
            if (out_valid === 1'b1 && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL sb_spurious: got %h expected no output", out_data);
                end else begin
                    logic [WIDTH-1:0] exp;
                    exp = sb.pop_front();
                    $display("[TB] out %h", out_data);
                    if (out_data !== exp) begin
                        fails++;
                        $display("[TB] FAIL sb_data: got %h expected %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                sb.push_back(in_data);
                $display("[TB] in  %h", in_data);
            end
            if (flush) sb.delete();
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (occupancy !== '0) begin
            fails++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
`ifdef PIPE_REG_DATA_RESET_EN
        tests++;
        if (out_data !== '0) begin
            fails++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
        end
`endif
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            out_ready = 1'b1;
            in_valid  = (c < 8);
            in_data   = WIDTH'(c + 1);
            @(negedge clk);
            tests++;
            if (out_valid !== (c >= 4 && c <= 11)) begin
                fails++; $display("[TB] FAIL stream_valid c=%0d: got %b expected %b", c, out_valid, (c >= 4 && c <= 11));
            end
            if (c >= 4 && c <= 11) begin
                tests++;
                if (out_data !== WIDTH'(c - 3)) begin
                    fails++; $display("[TB] FAIL stream_data c=%0d: got %h expected %h", c, out_data, WIDTH'(c - 3));
                end
            end
            if (c >= 4 && c <= 8) begin
                tests++;
                if (occupancy !== OCC_W'(4)) begin
                    fails++; $display("[TB] FAIL stream_occ c=%0d: got %0d expected 4", c, occupancy);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        int acc;
        int emits;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = WIDTH'(32'h100 + c);
            @(negedge clk);
            if (in_ready === 1'b1) acc++;
            if (c == 4) begin
                tests++;
                if (in_ready !== 1'b0 || occupancy !== OCC_W'(4)) begin
                    fails++; $display("[TB] FAIL bp_full: got in_ready=%b occ=%0d expected 0/4", in_ready, occupancy);
                end
            end
        end
        tests++;
        if (acc != 4) begin
            fails++; $display("[TB] FAIL bp_accepted: got %0d expected 4", acc);
        end
        emits = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            if (c == 0) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++; $display("[TB] FAIL bp_ready_return: got %b expected 1", in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                tests++;
                if (out_data !== WIDTH'(32'h100 + emits)) begin
                    fails++; $display("[TB] FAIL bp_order: got %h expected %h", out_data, WIDTH'(32'h100 + emits));
                end
                emits++;
            end
        end
        tests++;
        if (emits != 4) begin
            fails++; $display("[TB] FAIL bp_emitted: got %0d expected 4", emits);
        end
    endtask

    task automatic test_bubble();
        logic [WIDTH-1:0] a_val;
        logic [WIDTH-1:0] b_val;
        a_val = 32'hA5A5_0001;
        b_val = 32'h5A5A_0002;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            out_ready = 1'b0;
            in_valid  = (c == 0 || c == 3);
            in_data   = (c == 0) ? a_val : b_val;
        end
        @(negedge clk);
        tests++;
        if (occupancy !== OCC_W'(2) || out_valid !== 1'b1 || out_data !== a_val || in_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL bubble_hold: got occ=%0d v=%b d=%h rdy=%b expected 2/1/%h/1",
                              occupancy, out_valid, out_data, in_ready, a_val);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            tests++;
            if (c == 0 && (out_valid !== 1'b1 || out_data !== a_val)) begin
                fails++; $display("[TB] FAIL bubble_first: got v=%b d=%h expected 1/%h", out_valid, out_data, a_val);
            end else if (c == 1 && (out_valid !== 1'b1 || out_data !== b_val)) begin
                fails++; $display("[TB] FAIL bubble_second: got v=%b d=%h expected 1/%h", out_valid, out_data, b_val);
            end else if (c == 2 && out_valid !== 1'b0) begin
                fails++; $display("[TB] FAIL bubble_empty: got v=%b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = WIDTH'(32'h400 + c);
        end
        next_cycle();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || occupancy !== OCC_W'(3)) begin
            fails++; $display("[TB] FAIL flush_cycle: got rdy=%b occ=%0d expected 0/3", in_ready, occupancy);
        end
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || occupancy !== '0 || in_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL flush_after: got v=%b occ=%0d rdy=%b expected 0/0/1", out_valid, occupancy, in_ready);
        end
`ifdef PIPE_REG_DATA_RESET_EN
        tests++;
        if (out_data !== '0) begin
            fails++; $display("[TB] FAIL flush_data: got %h expected 0", out_data);
        end
`endif
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            out_ready = 1'b1;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++; $display("[TB] FAIL flush_stale c=%0d: got v=%b expected 0", c, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int budget;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = WIDTH'(32'h200 + c);
        end
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = WIDTH'(32'h300 + c);
            @(negedge clk);
            tests++;
            if (occupancy !== OCC_W'(4) || in_ready !== 1'b1 || out_valid !== 1'b1) begin
                fails++; $display("[TB] FAIL b2b_steady c=%0d: got occ=%0d rdy=%b v=%b expected 4/1/1",
                                  c, occupancy, in_ready, out_valid);
            end
        end
        budget = 0;
        do begin
            next_cycle();
            in_valid = 1'b0;
            @(negedge clk);
            budget++;
        end while ((occupancy !== '0 || out_valid !== 1'b0) && budget < 20);
        tests++;
        if (budget >= 20 || sb.size() != 0) begin
            fails++; $display("[TB] FAIL b2b_drain: got occ=%0d left=%0d expected 0/0", occupancy, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = WIDTH'(32'h500 + c);
        end
        next_cycle();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || occupancy !== '0 || in_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL midreset: got v=%b occ=%0d rdy=%b expected 0/0/1", out_valid, occupancy, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            out_ready = 1'b1;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++; $display("[TB] FAIL midreset_stale c=%0d: got v=%b expected 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_bubble();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
